mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 71 +++++++
 tb/tb_mem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, load/store and shared-memory handshake bundle for mem_arbiter
interface mem_arbiter_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   // arbiter view: masters and memory responses come in, grants and the shared request go out
   modport slave (
      input  inst_req, inst_addr,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
      input  mem_addr_ok, mem_data_ok, mem_rdata
   );

   // environment view: drives both masters and the memory side
   modport master (
      output inst_req, inst_addr,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
      output mem_addr_ok, mem_data_ok, mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority (data over inst) single-outstanding arbiter onto one memory port
module mem_arbiter (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave arb
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] DATA = 2'd2;
   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   logic [1:0]  state_q, state_d;
   logic        owner_q, owner_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        grant_data, grant_inst, addr_hs, data_hs;

   // Requests are only looked at in IDLE; memory handshakes only count in their own phase
   assign grant_data = (state_q == IDLE) && arb.data_req;
   assign grant_inst = (state_q == IDLE) && !arb.data_req && arb.inst_req;
   assign addr_hs    = (state_q == ADDR) && arb.mem_addr_ok;
   assign data_hs    = (state_q == DATA) && arb.mem_data_ok;

   // next state and payload capture at grant time
   always_comb begin
      state_d = (grant_data || grant_inst) ? ADDR :
                addr_hs ? DATA :
                data_hs ? IDLE : state_q;
      owner_d = grant_data ? OWN_DATA : grant_inst ? OWN_INST : owner_q;
      wr_d    = grant_data ? arb.data_wr : grant_inst ? 1'b0 : wr_q;
      size_d  = grant_data ? arb.data_size : grant_inst ? 2'b10 : size_q;
      addr_d  = grant_data ? arb.data_addr : grant_inst ? arb.inst_addr : addr_q;
      wdata_d = grant_data ? arb.data_wdata : grant_inst ? 32'd0 : wdata_q;
   end

   // state and latched payload registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= OWN_INST;
         wr_q    <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // mem payload comes only from the latched copy so master changes after grant cannot leak through
   assign arb.mem_req   = (state_q == ADDR);
   assign arb.mem_wr    = wr_q;
   assign arb.mem_size  = size_q;
   assign arb.mem_addr  = addr_q;
   assign arb.mem_wdata = wdata_q;

   assign arb.inst_addr_ok = addr_hs && (owner_q == OWN_INST);
   assign arb.data_addr_ok = addr_hs && (owner_q == OWN_DATA);
   assign arb.inst_data_ok = data_hs && (owner_q == OWN_INST);
   assign arb.data_data_ok = data_hs && (owner_q == OWN_DATA);
   assign arb.inst_rdata   = arb.mem_rdata;
   assign arb.data_rdata   = arb.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus randomized transactions checked against a pending-request model
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_arbiter_if bus();
   mem_arbiter dut (.clk(clk), .reset(reset), .arb(bus.slave));

   int errs = 0;
   int checks = 0;

   // model: which masters have an outstanding request and what they asked for
   bit          ip, dp;
   logic [31:0] ia, da, dw;
   logic        dwr;
   logic [1:0]  ds;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, ".mem_req"}, {31'd0, bus.mem_req}, 32'd0);
      chk({tag, ".acks"}, {28'd0, bus.inst_addr_ok, bus.inst_data_ok, bus.data_addr_ok, bus.data_data_ok}, 32'd0);
   endtask

   task automatic new_inst(input logic [31:0] a);
      ip = 1; ia = a;
      bus.inst_req = 1; bus.inst_addr = a;
   endtask

   task automatic new_data(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
      dp = 1; dwr = w; ds = s; da = a; dw = d;
      bus.data_req = 1; bus.data_wr = w; bus.data_size = s; bus.data_addr = a; bus.data_wdata = d;
   endtask

   // Called at a negedge of the grant (IDLE) cycle with requests already driven; returns
   // after the check of the cycle carrying mem_data_ok.
   task automatic txn(input int aw, input int dwc, input bit perturb, input logic [31:0] rd);
      logic own;
      logic        ewr;
      logic [1:0]  esz;
      logic [31:0] ead, ewd;
      own = dp;
      ewr = own ? dwr : 1'b0;
      esz = own ? ds : 2'b10;
      ead = own ? da : ia;
      ewd = own ? dw : 32'd0;
      #1 idle_chk("grant");
      for (int i = 0; i <= aw; i++) begin
         @(negedge clk);
         if (perturb) begin
            if (own) begin
               bus.data_addr = ead + 32'd4; bus.data_wdata = ~ewd; bus.data_wr = ~ewr; bus.data_size = ~esz;
            end else bus.inst_addr = ead + 32'd4;
         end
         bus.mem_addr_ok = (i == aw);
         bus.mem_data_ok = 1'($urandom % 2);
         #1;
         chk("addr.mem_req", {31'd0, bus.mem_req}, 32'd1);
         chk("addr.mem_addr", bus.mem_addr, ead);
         chk("addr.mem_wdata", bus.mem_wdata, ewd);
         chk("addr.wr_size", {29'd0, bus.mem_wr, bus.mem_size}, {29'd0, ewr, esz});
         chk("addr.inst_addr_ok", {31'd0, bus.inst_addr_ok}, {31'd0, (i == aw) && !own});
         chk("addr.data_addr_ok", {31'd0, bus.data_addr_ok}, {31'd0, (i == aw) && own});
         chk("addr.data_oks", {30'd0, bus.inst_data_ok, bus.data_data_ok}, 32'd0);
      end
      for (int j = 0; j <= dwc; j++) begin
         @(negedge clk);
         if (j == 0) begin
            if (own) begin bus.data_req = 0; dp = 0; end
            else begin bus.inst_req = 0; ip = 0; end
         end
         bus.mem_addr_ok = 1'($urandom % 2);
         bus.mem_data_ok = (j == dwc);
         bus.mem_rdata = (j == dwc) ? rd : $urandom;
         #1;
         chk("data.mem_req", {31'd0, bus.mem_req}, 32'd0);
         chk("data.addr_oks", {30'd0, bus.inst_addr_ok, bus.data_addr_ok}, 32'd0);
         chk("data.inst_data_ok", {31'd0, bus.inst_data_ok}, {31'd0, (j == dwc) && !own});
         chk("data.data_data_ok", {31'd0, bus.data_data_ok}, {31'd0, (j == dwc) && own});
         if (j == dwc) chk("data.rdata", own ? bus.data_rdata : bus.inst_rdata, rd);
      end
   endtask

   initial begin
      ip = 0; dp = 0;
      reset = 1;
      bus.inst_req = 0; bus.inst_addr = 0;
      bus.data_req = 0; bus.data_wr = 0; bus.data_size = 0; bus.data_addr = 0; bus.data_wdata = 0;
      bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      idle_chk("reset");
      chk("reset.payload", bus.mem_addr | bus.mem_wdata | {29'd0, bus.mem_wr, bus.mem_size}, 32'd0);
      reset = 0;

      // inst read, addr_ok on first ADDR cycle, data_ok two cycles later
      @(negedge clk);
      new_inst(32'hBFC00000);
      txn(0, 1, 0, 32'h3C1D0001);

      // simultaneous requests: data store first, inst read in the IDLE cycle after
      @(negedge clk);
      bus.mem_data_ok = 0; bus.mem_addr_ok = 0;
      new_inst(32'h00001230);
      new_data(1, 2'd2, 32'h80001000, 32'hDEADBEEF);
      txn(0, 0, 0, 32'h11111111);
      @(negedge clk);
      bus.mem_data_ok = 0; bus.mem_addr_ok = 0;
      txn(0, 0, 0, 32'h22222222);

      // address backpressure for five cycles
      @(negedge clk);
      bus.mem_data_ok = 0; bus.mem_addr_ok = 0;
      new_inst(32'h00004000);
      txn(5, 0, 0, 32'h33333333);

      // payload change while in ADDR
      @(negedge clk);
      bus.mem_data_ok = 0; bus.mem_addr_ok = 0;
      new_data(0, 2'd2, 32'h80000000, 32'h0);
      txn(2, 0, 1, 32'h44444444);

      // spurious mem_data_ok in IDLE
      @(negedge clk);
      bus.mem_data_ok = 1; bus.mem_addr_ok = 1;
      #1 idle_chk("spurious");
      @(negedge clk);
      bus.mem_data_ok = 0; bus.mem_addr_ok = 0;
      #1 idle_chk("spurious.after");

      // reset while in DATA, late mem_data_ok must not be forwarded
      @(negedge clk);
      bus.inst_req = 1; bus.inst_addr = 32'h00008000;
      @(negedge clk);
      bus.mem_addr_ok = 1;
      @(negedge clk);
      bus.inst_req = 0; bus.mem_addr_ok = 0;
      reset = 1;
      @(negedge clk);
      reset = 0;
      bus.mem_data_ok = 1; bus.mem_rdata = 32'h55555555;
      #1 idle_chk("rst_mid");
      chk("rst_mid.payload", bus.mem_addr | bus.mem_wdata | {29'd0, bus.mem_wr, bus.mem_size}, 32'd0);
      @(negedge clk);
      bus.mem_data_ok = 0;
      new_inst(32'h0000A000);
      txn(1, 1, 0, 32'h66666666);

      // randomized traffic
      repeat (60) begin
         @(negedge clk);
         bus.mem_addr_ok = 1'($urandom % 2);
         bus.mem_data_ok = 1'($urandom % 2);
         if (!ip && ($urandom % 3 != 0)) new_inst($urandom);
         if (!dp && ($urandom % 3 == 0)) new_data(1'($urandom % 2), 2'($urandom % 4), $urandom, $urandom);
         if (ip || dp) txn($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom % 2), $urandom);
         else #1 idle_chk("rand.idle");
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
